// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue
// Purpose  : Transmit-side byte queue and pacer in front of the UART
//            transmitter. Bytes pushed by the monitor are buffered in a
//            circular queue and handed to the UART one at a time. Each byte
//            waits for the UART busy handshake plus a programmable gap.
// Ports    : CLK               system clock
//            reset             synchronous, active-low reset
//            i_push            one-cycle write strobe
//            i_data_in         byte to enqueue (sampled when i_push=1)
//            o_full            queue holds 2^ADDR_WIDTH bytes
//            o_empty           queue holds 0 bytes
//            o_level           current occupancy
//            o_overflow        sticky: a push was dropped while full
//            o_busy            queue non-empty or pacer not idle
//            o_tx_byte         byte presented to the UART
//            o_transmit        one-cycle start pulse to the UART
//            i_is_transmitting UART busy flag
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int          ADDR_WIDTH    = 4,
    parameter logic [15:0] GAP_CYCLES    = 16'h0fff,
    parameter logic [15:0] START_TIMEOUT = 16'h00ff
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [7:0]            i_data_in,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_busy,
    output logic [7:0]            o_tx_byte,
    output logic                  o_transmit,
    input  logic                  i_is_transmitting
);

    localparam int              c_DEPTH_INT = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(c_DEPTH_INT);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_KICK       = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_GAP        = 3'd4
    } state_t;

    logic [7:0]            r_mem [0:c_DEPTH_INT-1];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_overflow;
    logic [7:0]            r_tx_byte;
    logic                  r_transmit;
    logic [15:0]           r_timer;
    state_t                r_state;

    logic [ADDR_WIDTH:0]   w_level;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_pop;
    logic                  w_transmit_next;
    logic [15:0]           w_timer_next;
    state_t                w_state_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // purely from their difference.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == c_DEPTH);
    assign w_empty = (w_level == '0);
    // Full is judged on registered pointers: a pop in the same cycle does not
    // make room for a push.
    assign w_wr_en = i_push & ~w_full;

    // Queue storage has no reset; resetting the pointers discards contents.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_data_in;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_timer_next    = r_timer;
        w_pop           = 1'b0;
        w_transmit_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !i_is_transmitting) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_KICK;
                end
            end
            ST_KICK: begin
                w_transmit_next = 1'b1;
                w_timer_next    = START_TIMEOUT;
                w_state_next    = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (i_is_transmitting) begin
                    w_state_next = ST_WAIT_DONE;
                end else if (r_timer == 16'd0) begin
                    // UART never acknowledged; the byte is abandoned, not retried.
                    w_timer_next = GAP_CYCLES;
                    w_state_next = ST_GAP;
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_is_transmitting) begin
                    w_timer_next = GAP_CYCLES;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_timer == 16'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_timer_next = 16'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= 16'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_transmit <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_transmit <= w_transmit_next;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_tx_byte <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_level    = w_level;
    assign o_overflow = r_overflow;
    assign o_busy     = ~w_empty | (r_state != ST_IDLE);
    assign o_tx_byte  = r_tx_byte;
    assign o_transmit = r_transmit;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_queue
// Purpose  : Directed self-checking bench for uart_tx_queue with a simple
//            UART model (busy rises one cycle after transmit, lasts FRAME).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int          AW    = 4;
    localparam logic [15:0] GAP   = 16'd20;
    localparam logic [15:0] STO   = 16'd10;
    localparam int          FRAME = 1042;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          is_tx;
    logic          full, empty, overflow, busy, transmit;
    logic [AW:0]   level;
    logic [7:0]    tx_byte;

    logic          uart_auto = 1'b0;
    logic          it_force = 1'b0;
    int            ucnt = 0;
    int            cyc = 0;
    logic [7:0]    sent[$];
    int            pulse_cyc[$];

    int            n_checks = 0;
    int            n_fail = 0;

    uart_tx_queue #(
        .ADDR_WIDTH(AW),
        .GAP_CYCLES(GAP),
        .START_TIMEOUT(STO)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .i_push(push),
        .i_data_in(data_in),
        .o_full(full),
        .o_empty(empty),
        .o_level(level),
        .o_overflow(overflow),
        .o_busy(busy),
        .o_tx_byte(tx_byte),
        .o_transmit(transmit),
        .i_is_transmitting(is_tx)
    );

    always #5 CLK = ~CLK;

    // UART model and transmit logger.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (transmit) begin
            sent.push_back(tx_byte);
            pulse_cyc.push_back(cyc);
        end
        if (transmit && uart_auto) ucnt <= FRAME;
        else if (ucnt != 0)       ucnt <= ucnt - 1;
    end
    assign is_tx = uart_auto ? (ucnt != 0) : it_force;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        push = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        sent.delete();
        pulse_cyc.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        data_in = b;
        push = 1'b1;
        @(negedge CLK);
        push = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%b after %0d cycles, expected 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        uart_auto = 1'b0;
        it_force  = 1'b0;
        push = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0)     begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (level !== 5'd0)    begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL reset_transmit: got %b expected 0", transmit); end
        n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_byte();
        int n;
        do_reset();
        uart_auto = 1'b1;
        push_byte(8'hA5);                       // after E0
        n_checks++; if (empty !== 1'b0)    begin n_fail++; $display("FAIL single_empty: got %b expected 0", empty); end
        n_checks++; if (level !== 5'd1)    begin n_fail++; $display("FAIL single_level: got %0d expected 1", level); end
        @(negedge CLK);                         // after E1
        n_checks++; if (tx_byte !== 8'hA5) begin n_fail++; $display("FAIL single_tx_byte: got %h expected a5", tx_byte); end
        n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL single_early_pulse: got %b expected 0", transmit); end
        @(negedge CLK);                         // after E2
        n_checks++; if (transmit !== 1'b1) begin n_fail++; $display("FAIL single_pulse: got %b expected 1", transmit); end
        @(negedge CLK);
        n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", transmit); end
        n = 0;
        while (is_tx === 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        n_checks++; if (n != FRAME) begin n_fail++; $display("FAIL single_frame_len: got %0d expected %0d", n, FRAME); end
        // First idle UART cycle: WAIT_DONE leaves at its end, GAP lasts GAP+1
        // cycles, so busy is still high GAP+1 cycles later and low one after.
        repeat (int'(GAP) + 1) @(negedge CLK);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_gap: got %b expected 1", busy); end
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
        n_checks++; if (pulse_cyc.size() != 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d expected 1", pulse_cyc.size()); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        uart_auto = 1'b0;
        it_force  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push_byte(8'(i));
            if (i == 15) begin
                n_checks++; if (full !== 1'b1)     begin n_fail++; $display("FAIL fill_full16: got %b expected 1", full); end
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf16: got %b expected 0", overflow); end
            end
        end
        n_checks++; if (full !== 1'b1)     begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
        n_checks++; if (level !== 5'd16)   begin n_fail++; $display("FAIL fill_level: got %0d expected 16", level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
        it_force  = 1'b0;
        uart_auto = 1'b1;
        wait_idle(40000, "fill");
        n_checks++; if (sent.size() != 16) begin n_fail++; $display("FAIL fill_sent_count: got %0d expected 16", sent.size()); end
        for (int i = 0; i < 16 && i < sent.size(); i++) begin
            n_checks++;
            if (sent[i] !== 8'(i)) begin n_fail++; $display("FAIL fill_order[%0d]: got %h expected %h", i, sent[i], 8'(i)); end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow_sticky: got %b expected 1", overflow); end
        uart_auto = 1'b0;
    endtask

    task automatic test_push_pop_wrap();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hB0; exp_b[1] = 8'hB1; exp_b[2] = 8'hB2; exp_b[3] = 8'hB3;
        do_reset();
        uart_auto = 1'b0;
        it_force  = 1'b0;
        // Advance both pointers to 12 using the timeout path.
        for (int i = 0; i < 12; i++) push_byte(8'h20 + 8'(i));
        wait_idle(2000, "wrap_pre");
        sent.delete();
        it_force = 1'b1;
        for (int i = 0; i < 3; i++) push_byte(exp_b[i]);     // wr_ptr = 15
        n_checks++; if (level !== 5'd3) begin n_fail++; $display("FAIL wrap_level_pre: got %0d expected 3", level); end
        // Release the UART and push on the same edge IDLE pops; wr_ptr 15 -> 16.
        it_force = 1'b0;
        push_byte(exp_b[3]);
        n_checks++; if (level !== 5'd3)    begin n_fail++; $display("FAIL wrap_level_same: got %0d expected 3", level); end
        n_checks++; if (tx_byte !== 8'hB0) begin n_fail++; $display("FAIL wrap_first_pop: got %h expected b0", tx_byte); end
        wait_idle(2000, "wrap");
        n_checks++; if (sent.size() != 4) begin n_fail++; $display("FAIL wrap_sent_count: got %0d expected 4", sent.size()); end
        for (int i = 0; i < 4 && i < sent.size(); i++) begin
            n_checks++;
            if (sent[i] !== exp_b[i]) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, sent[i], exp_b[i]); end
        end
    endtask

    task automatic test_start_timeout();
        int exp_gap;
        do_reset();
        uart_auto = 1'b0;
        it_force  = 1'b0;
        push_byte(8'hC1);
        push_byte(8'hC2);
        wait_idle(500, "timeout");
        // Pulse to pulse: WAIT_START (STO+1) + GAP (GAP+1) + IDLE + KICK.
        exp_gap = int'(STO) + 1 + int'(GAP) + 1 + 1 + 1;
        n_checks++; if (pulse_cyc.size() != 2) begin n_fail++; $display("FAIL timeout_pulses: got %0d expected 2", pulse_cyc.size()); end
        if (pulse_cyc.size() >= 2) begin
            n_checks++;
            if (pulse_cyc[1] - pulse_cyc[0] != exp_gap) begin
                n_fail++; $display("FAIL timeout_spacing: got %0d expected %0d", pulse_cyc[1] - pulse_cyc[0], exp_gap);
            end
            n_checks++;
            if (sent[0] !== 8'hC1 || sent[1] !== 8'hC2) begin
                n_fail++; $display("FAIL timeout_bytes: got %h %h expected c1 c2", sent[0], sent[1]);
            end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL timeout_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid();
        int n;
        int npulse;
        do_reset();
        uart_auto = 1'b1;
        for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
        n = 0;
        while (is_tx !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);              // now in WAIT_DONE
        n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL mid_level_pre: got %0d expected 5", level); end
        reset = 1'b0;
        @(negedge CLK);
        n_checks++; if (level !== 5'd0)    begin n_fail++; $display("FAIL mid_level: got %0d expected 0", level); end
        n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL mid_transmit: got %b expected 0", transmit); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
        n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL mid_tx_byte: got %h expected 00", tx_byte); end
        reset = 1'b1;
        npulse = pulse_cyc.size();
        repeat (1500) @(negedge CLK);
        n_checks++; if (pulse_cyc.size() != npulse) begin n_fail++; $display("FAIL mid_extra_pulses: got %0d expected %0d", pulse_cyc.size(), npulse); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty_after: got %b expected 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_push_pop_wrap();
        test_start_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
